// File: rtl/serdes_pkg.sv
// Shared widths and FSM encoding for the bit-serial to word demultiplexer.
package serdes_pkg;

    localparam int WIDTH = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } state_e;

endpackage

// File: rtl/serial_to_parallel_demux_if.sv
// Serial input beat channel and parallel output word channel of the demux.
interface serial_to_parallel_demux_if;
    import serdes_pkg::*;

    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SEL_W-1:0] slot;

    // Demux side: consumes serial beats, produces words and slot status.
    modport slave (
        input  in_valid,
        input  in_bit,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output slot
    );

    // Environment side: produces serial beats, consumes words.
    modport master (
        output in_valid,
        output in_bit,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  slot
    );

endinterface

// File: rtl/serial_to_parallel_demux_decoder_4to16.sv
// 4-to-16 one-hot write decoder: selects the shadow bit written by a beat.
module decoder_4to16
    import serdes_pkg::*;
(
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] y
);

    // One-hot enable for the selected slot, all-zero when not writing.
    always_comb begin
        y = '0;
        if (en) begin
            y = WIDTH'(1) << sel;
        end
    end

endmodule

// File: rtl/serial_to_parallel_demux.sv
// Rebuilds 16-bit words from a bit-serial stream; double-buffered output so
// capture of the next word continues while the consumer holds the previous one.
module serial_to_parallel_demux
    import serdes_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    serial_to_parallel_demux_if.slave   bus
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] slot_q, slot_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic             accept;
    logic             take;
    logic             complete;
    logic [SEL_W-1:0] wr_sel;
    logic [WIDTH-1:0] wr_en;
    logic [WIDTH-1:0] full_word;

    // For a 4-bit slot, 15 - slot is simply its bitwise inverse.
    always_comb begin
        accept   = bus.in_valid && in_ready_q;
        take     = out_valid_q && bus.out_ready;
        complete = accept && (slot_q == SEL_W'(WIDTH - 1));
        wr_sel   = LSB_FIRST ? slot_q : ~slot_q;
    end

    decoder_4to16 u_dec (
        .en  (accept),
        .sel (wr_sel),
        .y   (wr_en)
    );

    // Shadow word with the current beat merged into its decoded slot.
    always_comb begin
        full_word = (shadow_q & ~wr_en) | (wr_en & {WIDTH{bus.in_bit}});
    end

    // Next-state logic for the slot counter, shadow, output buffer and FSM.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        shadow_d    = shadow_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        case (state_q)
            FILL: begin
                if (take) begin
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    shadow_d = full_word;
                    slot_d   = slot_q + 1'b1;
                end
                if (complete) begin
                    if (!out_valid_q || bus.out_ready) begin
                        out_data_d  = full_word;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                // Output is occupied here, so a ready consumer swaps in the
                // parked word and the output stays valid.
                if (bus.out_ready) begin
                    out_data_d = shadow_q;
                    state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        in_ready_d = (state_d == FILL);
    end

    // All state registers; reset discards partial and held words.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FILL;
            slot_q      <= '0;
            shadow_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            shadow_q    <= shadow_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Registered outputs.
    always_comb begin
        bus.in_ready  = in_ready_q;
        bus.out_valid = out_valid_q;
        bus.out_data  = out_data_q;
        bus.slot      = slot_q;
    end

endmodule

// File: tb/tb_serial_to_parallel_demux.sv
// Bench for serial_to_parallel_demux: one LSB-first and one MSB-first instance,
// directed scenarios with literal expectations plus randomized traffic checked
// every cycle against a transaction-level model.
module tb_serial_to_parallel_demux;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic iv[2], ib[2], ordy[2];

    serial_to_parallel_demux_if if0 ();
    serial_to_parallel_demux_if if1 ();

    assign if0.in_valid  = iv[0];
    assign if0.in_bit    = ib[0];
    assign if0.out_ready = ordy[0];
    assign if1.in_valid  = iv[1];
    assign if1.in_bit    = ib[1];
    assign if1.out_ready = ordy[1];

    serial_to_parallel_demux #(.WIDTH(16), .LSB_FIRST(1'b1)) dut0 (
        .clk(clk), .reset(rst), .bus(if0.slave));
    serial_to_parallel_demux #(.WIDTH(16), .LSB_FIRST(1'b0)) dut1 (
        .clk(clk), .reset(rst), .bus(if1.slave));

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 1'b0;

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t",
                      name, k, act, exp, $time);
    endtask

    function automatic logic [31:0] dut_val(input int k, input int f);
        case (f)
            0: return (k == 0) ? 32'(if0.out_valid) : 32'(if1.out_valid);
            1: return (k == 0) ? 32'(if0.out_data)  : 32'(if1.out_data);
            2: return (k == 0) ? 32'(if0.in_ready)  : 32'(if1.in_ready);
            default: return (k == 0) ? 32'(if0.slot) : 32'(if1.slot);
        endcase
    endfunction

    // ---------------- behavioural model (word/transaction level) ------------
    // Output buffer (m_valid/m_data), at most one parked word (m_held), and a
    // word under construction: m_cnt bits received so far, assembled in m_word.
    bit          m_valid[2], m_held[2];
    logic [15:0] m_data[2], m_held_data[2], m_word[2];
    int          m_cnt[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0; m_held[k] = 0; m_data[k] = '0;
            m_held_data[k] = '0; m_word[k] = '0; m_cnt[k] = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_valid[k] = 0; m_held[k] = 0; m_data[k] = '0;
                m_word[k] = '0; m_cnt[k] = 0;
            end else if (m_held[k]) begin
                if (ordy[k]) begin
                    m_data[k] = m_held_data[k];
                    m_held[k] = 0;
                end
            end else begin
                bit was_valid;
                was_valid = m_valid[k];
                if (m_valid[k] && ordy[k]) m_valid[k] = 0;
                if (iv[k]) begin
                    int pos;
                    pos = (k == 0) ? m_cnt[k] : 15 - m_cnt[k];
                    m_word[k][pos] = ib[k];
                    m_cnt[k]++;
                    if (m_cnt[k] == 16) begin
                        if (!was_valid || ordy[k]) begin
                            m_data[k]  = m_word[k];
                            m_valid[k] = 1;
                        end else begin
                            m_held[k]      = 1;
                            m_held_data[k] = m_word[k];
                        end
                        m_cnt[k]  = 0;
                        m_word[k] = '0;
                    end
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk("model_out_valid", k, dut_val(k, 0), 32'(m_valid[k]));
                chk("model_out_data",  k, dut_val(k, 1), 32'(m_data[k]));
                chk("model_in_ready",  k, dut_val(k, 2), 32'(!m_held[k]));
                chk("model_slot",      k, dut_val(k, 3), 32'(m_cnt[k]));
            end
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Drive bit number i (in transmit order) of word w on instance k.
    task automatic drive_bit(input int k, input logic [15:0] w, input int i);
        iv[k] = 1'b1;
        ib[k] = (k == 0) ? w[i] : w[15 - i];
    endtask

    task automatic send_word(input int k, input logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            drive_bit(k, w, i);
            step();
        end
        iv[k] = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------------------
    initial begin
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b1; ib[k] = 1'b1; ordy[k] = 1'b0;
        end

        // Reset held two cycles with in_valid high.
        rst = 1'b1;
        step();
        started = 1'b1;
        step();
        chk("rst_out_valid", 0, dut_val(0, 0), 32'h0);
        chk("rst_out_data",  0, dut_val(0, 1), 32'h0);
        chk("rst_slot",      0, dut_val(0, 3), 32'h0);
        chk("rst_in_ready",  0, dut_val(0, 2), 32'h1);
        rst = 1'b0;
        iv[0] = 1'b0; iv[1] = 1'b0;

        // Single word, LSB first, back-to-back beats.
        ordy[0] = 1'b1;
        send_word(0, 16'hA5C3);
        chk("lsb_word_valid", 0, dut_val(0, 0), 32'h1);
        chk("lsb_word_data",  0, dut_val(0, 1), 32'hA5C3);
        step();
        chk("lsb_valid_drop", 0, dut_val(0, 0), 32'h0);

        // MSB first with a gap after every beat; slot must step and hold.
        ordy[1] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_bit(1, 16'h8001, i);
            step();
            chk("msb_slot_step", 1, dut_val(1, 3), 32'((i + 1) % 16));
            if (i == 15) chk("msb_word_data", 1, dut_val(1, 1), 32'h8001);
            iv[1] = 1'b0;
            step();
            chk("msb_slot_hold", 1, dut_val(1, 3), 32'((i + 1) % 16));
        end

        // Backpressure: second word parks, input stalls.
        ordy[0] = 1'b0;
        send_word(0, 16'h1234);
        chk("bp_first_valid", 0, dut_val(0, 0), 32'h1);
        chk("bp_first_data",  0, dut_val(0, 1), 32'h1234);
        send_word(0, 16'hFFFF);
        chk("bp_stall_ready", 0, dut_val(0, 2), 32'h0);
        chk("bp_hold_data",   0, dut_val(0, 1), 32'h1234);
        iv[0] = 1'b1; ib[0] = 1'b0;
        step(); step();
        chk("bp_ignored_slot", 0, dut_val(0, 3), 32'h0);
        chk("bp_still_data",   0, dut_val(0, 1), 32'h1234);
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        step();
        chk("bp_swap_data",  0, dut_val(0, 1), 32'hFFFF);
        chk("bp_swap_valid", 0, dut_val(0, 0), 32'h1);
        chk("bp_swap_ready", 0, dut_val(0, 2), 32'h1);
        step();
        chk("bp_drain_valid", 0, dut_val(0, 0), 32'h0);

        // Completion in the same cycle the previous word is taken.
        ordy[0] = 1'b0;
        send_word(0, 16'h1111);
        for (int i = 0; i < 16; i++) begin
            drive_bit(0, 16'h0F0F, i);
            if (i == 15) ordy[0] = 1'b1;
            step();
        end
        iv[0] = 1'b0;
        chk("sim_data",  0, dut_val(0, 1), 32'h0F0F);
        chk("sim_valid", 0, dut_val(0, 0), 32'h1);
        chk("sim_ready", 0, dut_val(0, 2), 32'h1);
        step();
        ordy[0] = 1'b0;

        // Reset in the middle of a word.
        for (int i = 0; i < 7; i++) begin
            drive_bit(0, 16'hFFFF, i);
            step();
        end
        iv[0] = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_slot",  0, dut_val(0, 3), 32'h0);
        chk("midrst_valid", 0, dut_val(0, 0), 32'h0);
        ordy[0] = 1'b1;
        send_word(0, 16'h5555);
        chk("midrst_data", 0, dut_val(0, 1), 32'h5555);

        // Randomized traffic on both instances with rare resets.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            for (int k = 0; k < 2; k++) begin
                iv[k]   = ($urandom_range(0, 3) != 0);
                ib[k]   = 1'($urandom_range(0, 1));
                ordy[k] = ($urandom_range(0, 9) < 4);
            end
            step();
        end
        rst = 1'b0;
        iv[0] = 1'b0; iv[1] = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_demux.md
Name: serial_to_parallel_demux

Overview:
- Collects a serial bit stream into a 16-bit word, one bit per accepted beat, and presents completed words on a parallel output with valid/ready.
- Inverse of the 16:1 selector path: a 4-bit slot counter drives a 4-to-16 one-hot write decoder that steers each incoming bit into its slot of a shadow word.
- Used wherever the pipeline needs a word rebuilt from a bit-serial source, e.g. debug/scan capture and test loaders.
- Output is double-buffered, so bit capture continues while the previous word waits for the consumer.

Parameters:
- WIDTH, 16, word width; fixed at 16 in this revision; SEL_W = 4 is a derived localparam.
- LSB_FIRST, 1, 1: first bit of a word lands in data[0]; 0: first bit lands in data[15].

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial data bit.
- in_ready  output  1  block accepts a bit this cycle.
- out_valid  output  1  out_data holds a completed word.
- out_ready  input  1  consumer takes the word this cycle.
- out_data  output  16  completed word.
- slot  output  4  index of the next bit position to be written; status only.

Behaviour:
- One clock is decided: clk. Reset is synchronous and active-high: reset.
- Beat acceptance: a bit is accepted when in_valid && in_ready at a rising clk edge. Word transfer: a word is taken when out_valid && out_ready.
- Reset, sampled at an edge: slot = 0, shadow = 0, out_data = 0, out_valid = 0, state = FILL. After reset, in_ready = 1.
- Reset mid-word or mid-stall discards the partial shadow word and any held output word.
- States:
  - FILL: in_ready = 1.
  - STALL: in_ready = 0. A complete word is in shadow, and the output register is still occupied.
- Write path in FILL, on an accepted beat:
  - The decoder asserts exactly one enable, idx = LSB_FIRST ? slot : 15 - slot.
  - shadow[idx] <= in_bit. All other shadow bits hold.
  - slot <= slot + 1, wrapping 15 -> 0.
- Completion is the accepted beat with slot == 15. The full word is the shadow with the final bit merged in.
  - If out_valid == 0, or out_ready == 1 in the same cycle: out_data <= full word, out_valid <= 1, stay in FILL.
  - Otherwise: keep the full word in shadow, go to STALL, slot = 0.
- Latency: out_valid rises in the cycle after the 16th bit is accepted.
- STALL: when out_ready is high, out_data <= shadow, out_valid stays 1, return to FILL. in_ready = 1 from the next cycle.
- Output hold: while out_valid && !out_ready, out_data and out_valid are stable.
  - A transfer with no new word completing that cycle: out_valid <= 0 and out_data holds its old value.
- Shadow is never cleared between words. Every bit of a new word is overwritten, so no stale data reaches the output.
- in_valid gaps of any length are legal. slot and shadow hold during gaps.
- in_bit is ignored when in_valid == 0 or in_ready == 0.
- out_ready is ignored when out_valid == 0.

Decomposition:
- Package serdes_pkg holds WIDTH = 16, SEL_W = 4, and the state enum typedef {FILL, STALL}.
- Sub-module decoder_4to16: inputs en (1 bit) and sel (4 bits); output y (16 bits) = en ? (1 << sel) : 0. Purely combinational.
- The top level holds the counter, the shadow/output registers and the FSM.

Test Plan:
- Reset: assert reset for 2 cycles with in_valid = 1 -> out_valid = 0, out_data = 0x0000, slot = 0, in_ready = 1.
- Single word, LSB_FIRST = 1: send the bits of 0xA5C3 LSB first, back-to-back, with out_ready = 1 -> out_data = 0xA5C3 and out_valid = 1 one cycle after the 16th beat, low the cycle after.
- Gaps and MSB order: LSB_FIRST = 0, send 0x8001 MSB first with in_valid low every other cycle -> out_data = 0x8001. slot reads 0, 1, ..., 15 and holds during gaps.
- Backpressure: out_ready = 0 while sending 0x1234 then 0xFFFF -> 0x1234 held, FSM in STALL, in_ready = 0.
  - Then raise out_ready for 1 cycle -> out_data = 0xFFFF and out_valid stays 1.
  - Raise it again -> out_valid = 0.
- Simultaneous events: 16th bit of 0x0F0F accepted in the same cycle 0x1111 is taken -> next cycle out_data = 0x0F0F, out_valid = 1, no stall.
- Reset mid-word: send 7 bits, pulse reset, then send a full 0x5555 -> out_data = 0x5555 with no residue, slot starts at 0.
